// File: rtl/aes_spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : aes_spi_master_mc
// Description : SPI master that ships one AES job (128-bit block followed by
//               an NK*32-bit key) to one of N_CH cipher slaves and shifts back
//               the 128-bit result. Generated SCLK (half-period DIV clocks),
//               GAP idle bit periods between transmit and receive, and a
//               start/busy/done handshake with error reporting.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: AES_SPI_ABORT_EN
//   defined   -> adds input 'abort'; abort in SEND/GAP/RECV ends the job with
//                done=1, err=1 on the next cycle.
//   undefined -> no abort port; jobs run to completion or reset.
// ----------------------------------------------------------------------------
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset (aborts a job silently)
//   start     in   job request, sampled only in IDLE
//   abort     in   (AES_SPI_ABORT_EN only) abort the running job
//   ch_sel    in   [CH_W]    target slave index, captured with start
//   data_in   in   [128]     block, captured with start
//   key       in   [NK*32]   key, captured with start
//   busy      out  high from the cycle after accept until done
//   done      out  one-cycle pulse at job end
//   err       out  valid with done: bad ch_sel or abort
//   data_out  out  [128]     received result, updated on error-free done
//   sclk      out  serial clock, idle low
//   mosi      out  serial data out, MSB first
//   cs_n      out  [N_CH]    active-low chip selects
//   miso      in   [N_CH]    per-channel serial data in
// ============================================================================
module aes_spi_master_mc #(
    parameter int NK   = 4,
    parameter int N_CH = 2,
    parameter int CH_W = 3,
    parameter int DIV  = 1,
    parameter int GAP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef AES_SPI_ABORT_EN
    input  logic              abort,
`endif
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [127:0]      data_in,
    input  logic [NK*32-1:0]  key,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [127:0]      data_out,
    output logic              sclk,
    output logic              mosi,
    output logic [N_CH-1:0]   cs_n,
    input  logic [N_CH-1:0]   miso
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int SEND_BITS = 128 + NK * 32;
    localparam int CNT_MAX   = (GAP > SEND_BITS) ? GAP : SEND_BITS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(SEND_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(127);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);

    // State encoding. TAIL is the single cycle after the final falling sclk
    // edge: it keeps cs_n low so cs_n never rises in the same cycle that
    // sclk falls at job end.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_RECV = 3'd3;
    localparam logic [2:0] S_TAIL = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [127:0]          r_data_out;
    logic                  r_sclk;
    logic                  r_mosi;
    logic [N_CH-1:0]       r_cs_n;
    logic [CH_W-1:0]       r_ch;
    logic [SEND_BITS-1:0]  r_shift;
    logic [127:0]          r_rx;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DIV_W-1:0]      r_div_cnt;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_tick;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_ch_ok;
    logic                  w_abort;
    logic                  w_miso_bit;
    logic [N_CH-1:0]       w_cs_sel;

    // w_tick marks the clk edge where sclk toggles; the direction of the
    // toggle tells whether this is the sampling (rise) or shifting (fall)
    // edge of the current bit period.
    assign w_tick  = (r_div_cnt == DIV_LAST);
    assign w_rise  = w_tick && !r_sclk;
    assign w_fall  = w_tick && r_sclk;
    assign w_ch_ok = (32'(ch_sel) < 32'(N_CH));

`ifdef AES_SPI_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Decode of the requested channel into a one-hot-low chip select.
    // An out-of-range ch_sel decodes to all ones (never used for a job).
    always_comb begin
        w_cs_sel = '1;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                w_cs_sel[i] = 1'b0;
            end
        end
    end

    // miso of the channel latched at accept.
    always_comb begin
        w_miso_bit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_ch == CH_W'(i)) begin
                w_miso_bit = miso[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Main state machine and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_data_out <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
            r_ch       <= '0;
            r_shift    <= '0;
            r_rx       <= '0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
        end else begin
            // done/err are single-cycle pulses by default
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_ch_ok) begin
                            r_state   <= S_SEND;
                            r_busy    <= 1'b1;
                            r_cs_n    <= w_cs_sel;
                            r_ch      <= ch_sel;
                            r_shift   <= {data_in, key};
                            r_mosi    <= data_in[127];
                            r_sclk    <= 1'b0;
                            r_div_cnt <= '0;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= S_ERR;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end

                S_SEND, S_GAP, S_RECV: begin
                    if (w_abort) begin
                        r_state <= S_ERR;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cs_n  <= '1;
                        r_sclk  <= 1'b0;
                        r_mosi  <= 1'b0;
                    end else begin
                        if (w_tick) begin
                            r_div_cnt <= '0;
                            r_sclk    <= ~r_sclk;
                        end else begin
                            r_div_cnt <= r_div_cnt + 1'b1;
                        end

                        if (w_rise && (r_state == S_RECV)) begin
                            r_rx <= {r_rx[126:0], w_miso_bit};
                        end

                        // Falling sclk closes a bit period.
                        if (w_fall) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            case (r_state)
                                S_SEND: begin
                                    if (r_bit_cnt == SEND_LAST) begin
                                        r_bit_cnt <= '0;
                                        r_mosi    <= 1'b0;
                                        r_state   <= (GAP > 0) ? S_GAP : S_RECV;
                                    end else begin
                                        r_shift <= r_shift << 1;
                                        r_mosi  <= r_shift[SEND_BITS-2];
                                    end
                                end
                                S_GAP: begin
                                    if (r_bit_cnt == GAP_LAST) begin
                                        r_bit_cnt <= '0;
                                        r_state   <= S_RECV;
                                    end
                                end
                                S_RECV: begin
                                    if (r_bit_cnt == RECV_LAST) begin
                                        r_bit_cnt <= '0;
                                        r_state   <= S_TAIL;
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end

                S_TAIL: begin
                    r_state    <= S_DONE;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_cs_n     <= '1;
                    r_data_out <= r_rx;
                end

                // DONE/ERR are the cycles where the done pulse is visible;
                // start is deliberately not sampled here.
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign data_out = r_data_out;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_spi_master_mc
// Description : Directed self-checking bench for aes_spi_master_mc. Two
//               instances: A (NK=4, DIV=1, GAP=4) and B (NK=8, DIV=3, GAP=0),
//               each with a behavioural slave returning a fixed result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_spi_master_mc;

    localparam logic [127:0] PT       = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY128   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R_ENC    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R_ENC256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A ----------------
    logic         start_a = 1'b0;
    logic         abort_a = 1'b0;
    logic [2:0]   ch_sel_a = '0;
    logic [127:0] data_in_a = '0;
    logic [127:0] key_a = '0;
    logic         busy_a, done_a, err_a, sclk_a, mosi_a;
    logic [127:0] data_out_a;
    logic [1:0]   cs_n_a;
    logic [1:0]   miso_a;

    aes_spi_master_mc #(.NK(4), .N_CH(2), .CH_W(3), .DIV(1), .GAP(4)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
`ifdef AES_SPI_ABORT_EN
        .abort    (abort_a),
`endif
        .ch_sel   (ch_sel_a),
        .data_in  (data_in_a),
        .key      (key_a),
        .busy     (busy_a),
        .done     (done_a),
        .err      (err_a),
        .data_out (data_out_a),
        .sclk     (sclk_a),
        .mosi     (mosi_a),
        .cs_n     (cs_n_a),
        .miso     (miso_a)
    );

    // ---------------- instance B ----------------
    logic         start_b = 1'b0;
    logic [2:0]   ch_sel_b = '0;
    logic [127:0] data_in_b = '0;
    logic [255:0] key_b = '0;
    logic         busy_b, done_b, err_b, sclk_b, mosi_b;
    logic [127:0] data_out_b;
    logic [1:0]   cs_n_b;
    logic [1:0]   miso_b;

    aes_spi_master_mc #(.NK(8), .N_CH(2), .CH_W(3), .DIV(3), .GAP(0)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
`ifdef AES_SPI_ABORT_EN
        .abort    (1'b0),
`endif
        .ch_sel   (ch_sel_b),
        .data_in  (data_in_b),
        .key      (key_b),
        .busy     (busy_b),
        .done     (done_b),
        .err      (err_b),
        .data_out (data_out_b),
        .sclk     (sclk_b),
        .mosi     (mosi_b),
        .cs_n     (cs_n_b),
        .miso     (miso_b)
    );

    // ---------------- slave models ----------------
    // rcnt counts rising sclk edges since the chip select went low; the
    // receive bit for edge r is presented while rcnt == r.
    wire [127:0] resp_a0 = R_ENC;
    wire [127:0] resp_a1 = PT;
    wire [127:0] resp_b0 = R_ENC256;

    int           rcnt_a = 0, edges_a = 0;
    logic [383:0] cap_a = '0;
    wire          cs_idle_a = &cs_n_a;

    always @(posedge sclk_a or posedge cs_idle_a) begin
        if (cs_idle_a) begin
            rcnt_a <= 0;
        end else begin
            if (rcnt_a == 0) cap_a <= {383'b0, mosi_a};
            else if (rcnt_a < 256) cap_a <= {cap_a[382:0], mosi_a};
            edges_a <= rcnt_a + 1;
            rcnt_a  <= rcnt_a + 1;
        end
    end

    always_comb begin
        miso_a = 2'b00;
        if (rcnt_a >= 260 && rcnt_a < 388) begin
            if (!cs_n_a[0]) miso_a[0] = resp_a0[7'(387 - rcnt_a)];
            if (!cs_n_a[1]) miso_a[1] = resp_a1[7'(387 - rcnt_a)];
        end
    end

    int           rcnt_b = 0, edges_b = 0;
    logic [383:0] cap_b = '0;
    wire          cs_idle_b = &cs_n_b;

    always @(posedge sclk_b or posedge cs_idle_b) begin
        if (cs_idle_b) begin
            rcnt_b <= 0;
        end else begin
            if (rcnt_b == 0) cap_b <= {383'b0, mosi_b};
            else if (rcnt_b < 384) cap_b <= {cap_b[382:0], mosi_b};
            edges_b <= rcnt_b + 1;
            rcnt_b  <= rcnt_b + 1;
        end
    end

    always_comb begin
        miso_b = 2'b00;
        if (rcnt_b >= 384 && rcnt_b < 512 && !cs_n_b[0])
            miso_b[0] = resp_b0[7'(511 - rcnt_b)];
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Runs one full job on instance A; called at a negedge with A idle,
    // returns at the negedge where done is visible.
    task automatic run_job_a(input int ch, input logic [127:0] exp_out, input string tag);
        int k, bad_cs;
        logic [1:0] exp_cs, prev_cs;
        logic prev_sclk;
        exp_cs = (ch == 0) ? 2'b10 : 2'b01;
        start_a = 1'b1; ch_sel_a = 3'(ch); data_in_a = PT; key_a = KEY128;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0; ch_sel_a = 3'd7; data_in_a = '0; key_a = '0;
        chk({tag, "_busy0"}, 384'(busy_a), 384'(1));
        chk({tag, "_cs0"}, 384'(cs_n_a), 384'(exp_cs));
        chk({tag, "_sclk0"}, 384'(sclk_a), 384'(0));
        chk({tag, "_mosi0"}, 384'(mosi_a), 384'(PT[127]));
        k = 0; bad_cs = 0; prev_cs = cs_n_a; prev_sclk = sclk_a;
        while (!done_a && k < 2000) begin
            prev_cs = cs_n_a; prev_sclk = sclk_a;
            @(negedge clk);
            k++;
            if (!done_a && cs_n_a !== exp_cs) bad_cs++;
        end
        chk({tag, "_latency"}, 384'(k), 384'(777));
        chk({tag, "_err"}, 384'(err_a), 384'(0));
        chk({tag, "_data_out"}, 384'(data_out_a), 384'(exp_out));
        chk({tag, "_cs_end"}, 384'(cs_n_a), 384'(2'b11));
        chk({tag, "_busy_end"}, 384'(busy_a), 384'(0));
        chk({tag, "_sclk_end"}, 384'(sclk_a), 384'(0));
        chk({tag, "_cs_tail"}, 384'(prev_cs), 384'(exp_cs));
        chk({tag, "_sclk_tail"}, 384'(prev_sclk), 384'(0));
        chk({tag, "_cs_stable"}, 384'(bad_cs), 384'(0));
        chk({tag, "_mosi_stream"}, cap_a, {128'b0, PT, KEY128});
        chk({tag, "_sclk_edges"}, 384'(edges_a), 384'(388));
    endtask

    initial begin
        int k, done_seen, first_rise;

        // reset
        repeat (3) @(negedge clk);
        chk("rst_busy", 384'(busy_a), 384'(0));
        chk("rst_done", 384'(done_a), 384'(0));
        chk("rst_err", 384'(err_a), 384'(0));
        chk("rst_data_out", 384'(data_out_a), 384'(0));
        chk("rst_sclk", 384'(sclk_a), 384'(0));
        chk("rst_mosi", 384'(mosi_a), 384'(0));
        chk("rst_cs_n", 384'(cs_n_a), 384'(2'b11));
        chk("rst_cs_n_b", 384'(cs_n_b), 384'(2'b11));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // job 1: cipher slave on channel 0
        run_job_a(0, R_ENC, "ch0");
        @(negedge clk);
        chk("ch0_done_pulse", 384'(done_a), 384'(0));

        // job 2: inverse slave on channel 1; start raised in the DONE cycle
        // with an out-of-range channel
        run_job_a(1, PT, "ch1");
        start_a = 1'b1; ch_sel_a = 3'd5;
        @(negedge clk);
        chk("done_cycle_start_ignored", 384'(done_a), 384'(0));
        chk("done_cycle_busy", 384'(busy_a), 384'(0));
        @(negedge clk);
        start_a = 1'b0;
        chk("badch_done", 384'(done_a), 384'(1));
        chk("badch_err", 384'(err_a), 384'(1));
        chk("badch_cs_n", 384'(cs_n_a), 384'(2'b11));
        chk("badch_data_out", 384'(data_out_a), 384'(PT));
        chk("badch_busy", 384'(busy_a), 384'(0));
        @(negedge clk);
        chk("badch_done_pulse", 384'(done_a), 384'(0));
        chk("badch_err_pulse", 384'(err_a), 384'(0));

        // job 3: restart while busy is ignored, then reset at SEND bit 50
        start_a = 1'b1; ch_sel_a = 3'd0; data_in_a = PT; key_a = KEY128;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (100) @(negedge clk);
        start_a = 1'b1; ch_sel_a = 3'd1;
        @(negedge clk);
        start_a = 1'b0;
        chk("busy_restart_cs", 384'(cs_n_a), 384'(2'b10));
        chk("busy_restart_busy", 384'(busy_a), 384'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 384'(busy_a), 384'(0));
        chk("midrst_data_out", 384'(data_out_a), 384'(0));
        chk("midrst_sclk", 384'(sclk_a), 384'(0));
        chk("midrst_mosi", 384'(mosi_a), 384'(0));
        chk("midrst_cs_n", 384'(cs_n_a), 384'(2'b11));
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_a || busy_a) done_seen++;
        end
        chk("midrst_no_done", 384'(done_seen), 384'(0));

        // job 4: new job after reset
        run_job_a(1, PT, "post_rst");
        @(negedge clk);

        // instance B: NK=8, DIV=3, GAP=0
        start_b = 1'b1; ch_sel_b = 3'd0; data_in_b = PT; key_b = KEY256;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0; data_in_b = '0; key_b = '0;
        chk("b_cs0", 384'(cs_n_b), 384'(2'b10));
        k = 0; first_rise = -1;
        while (!done_b && k < 5000) begin
            @(negedge clk);
            k++;
            if (sclk_b && first_rise < 0) first_rise = k;
        end
        chk("b_first_rise", 384'(first_rise), 384'(3));
        chk("b_latency", 384'(k), 384'(3073));
        chk("b_err", 384'(err_b), 384'(0));
        chk("b_data_out", 384'(data_out_b), 384'(R_ENC256));
        chk("b_mosi_stream", cap_b, {PT, KEY256});
        chk("b_sclk_edges", 384'(edges_b), 384'(512));
        chk("b_cs_end", 384'(cs_n_b), 384'(2'b11));

`ifdef AES_SPI_ABORT_EN
        // abort during RECV bit 10 on instance A
        @(negedge clk);
        start_a = 1'b1; ch_sel_a = 3'd0; data_in_a = PT; key_a = KEY128;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (541) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_cs_n", 384'(cs_n_a), 384'(2'b11));
        chk("abort_done", 384'(done_a), 384'(1));
        chk("abort_err", 384'(err_a), 384'(1));
        chk("abort_sclk", 384'(sclk_a), 384'(0));
        chk("abort_mosi", 384'(mosi_a), 384'(0));
        chk("abort_data_out", 384'(data_out_a), 384'(PT));
        @(negedge clk);
        chk("abort_done_pulse", 384'(done_a), 384'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_spi_master_mc.md
Name: aes_spi_master_mc

Overview:
Parametrised SPI master that ships one AES job (128-bit block followed by an NK*32-bit key) to one of N_CH cipher/inverse-cipher slaves and shifts back the 128-bit result.
- Generalises the fixed two-slave, free-running master: selectable channel count, generated SCLK with divider, programmable turnaround gap, and an explicit start/busy/done handshake with error reporting.
- Sits between the AES top-level controller and the per-mode AES slave engines.

Parameters:
NK, 4, key length in 32-bit words (4/6/8 for AES-128/192/256)
N_CH, 2, number of slave channels (each has its own cs_n and miso), 1..8
CH_W, 3, width of ch_sel; must satisfy 2**CH_W >= N_CH
DIV, 1, SCLK half-period in clk cycles (>=1)
GAP, 4, idle SCLK periods between the last transmitted bit and the first received bit

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a job; sampled only in IDLE
ch_sel  input  CH_W  target slave index, captured with start
data_in  input  128  block to process, captured with start
key  input  NK*32  key, captured with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at job end
err  output  1  valid with done: 1 = ch_sel out of range (or abort)
data_out  output  128  received result, updated only at done with err=0
sclk  output  1  serial clock, idle low
mosi  output  1  serial data out, MSB first
cs_n  output  N_CH  active-low chip selects, one-hot-low or all high
miso  input  N_CH  per-channel serial data in

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; busy=0, done=0, err=0, data_out=0, sclk=0, mosi=0, cs_n=all 1; bit/gap/divider counters=0. Reset applied mid-job aborts the job silently (no done pulse).
- Shift register: {data_in, key} latched on accept; mosi = MSB, shifted left once per SCLK period.
- SCLK: toggles every DIV clk cycles while in SEND/GAP/RECV; one bit period = 2*DIV cycles. mosi changes coincident with the falling sclk edge (and at entry to SEND); miso is sampled on the rising sclk edge.
- FSM:
  - IDLE: start=1 with ch_sel<N_CH -> SEND; cs_n[ch_sel]=0, busy=1 the next cycle. If start=1 with ch_sel>=N_CH -> ERR.
  - SEND: 128+NK*32 bit periods -> GAP.
  - GAP: GAP bit periods, mosi=0, miso ignored, sclk keeps running -> RECV. If GAP=0, go straight to RECV.
  - RECV: 128 bit periods; rx = {rx[126:0], miso[ch]} on each rising sclk -> DONE.
  - DONE: one cycle; done=1, err=0, data_out=rx, cs_n=all 1, sclk=0, busy=0 -> IDLE.
  - ERR: one cycle; done=1, err=1, data_out unchanged, no cs_n asserted -> IDLE.
- Latency: done asserts exactly 2*DIV*(256+NK*32+GAP)+1 cycles after the start-accept edge.
- start while busy is ignored (not queued). Inputs other than miso are don't-care after accept.
- start in the DONE cycle is ignored; it is accepted the following cycle if still high.
- Only one cs_n bit is ever low; cs_n and sclk never change in the same cycle at job start or job end.

Optional Feature:
Macro AES_SPI_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in SEND/GAP/RECV -> next cycle cs_n=all 1, sclk=0, mosi=0; one-cycle done with err=1; data_out unchanged; return to IDLE. abort in IDLE/DONE/ERR is ignored.
- Undefined: no abort port; jobs always run to completion or reset.

Test Plan:
- NK=4, DIV=1, GAP=4, ch_sel=0, data_in=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f; slave model returns 69c4e0d86a7b0430d8cdb78070b4c55a -> mosi stream equals data_in||key MSB first; done after 2*(128+128+4+128)+1=777 cycles; data_out=69c4…c55a; err=0.
- Same job on ch_sel=1 with the inverse slave model returning 00112233445566778899aabbccddeeff -> only cs_n[1] low throughout; data_out matches; cs_n[0] stays 1.
- NK=8, DIV=3, GAP=0 -> sclk period 6 cycles; 384 bits sent, then immediate receive; done at 6*(256+256)+1=3073 cycles.
- start with ch_sel=5 (N_CH=2) -> done=1 and err=1 one cycle later; cs_n stays 2'b11; data_out unchanged.
- rst pulsed mid-SEND at bit 50, then start re-pulsed mid-job -> all outputs return to reset values, no done pulse; a second start pulsed while busy is ignored, and a new job after reset completes correctly.
- With AES_SPI_ABORT_EN: abort during RECV bit 10 -> next cycle cs_n all 1, done=1, err=1; data_out keeps its previous value.
